// File: rtl/bcd_counter_sync_n.sv
// Synchronous multi-digit BCD up/down counter with load, clear and wrap flags.
// Define BCD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module bcd_counter_sync_n #(
  parameter int                  DIGITS = 3,
  parameter logic [4*DIGITS-1:0] INIT   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_sync_n: DIGITS must be 1..8");
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_init_chk
    if (INIT[4*g +: 4] > 4'd9) begin : g_bad_init
      $error("bcd_counter_sync_n: INIT nibble is not BCD");
    end
  end

  logic [4*DIGITS-1:0] r_count;
  logic                r_wrap;
  logic                r_load_err;

  logic [4*DIGITS-1:0] w_cnt_nxt;
  logic [4*DIGITS-1:0] w_load_bcd;
  logic [DIGITS-1:0]   w_nine;
  logic [DIGITS-1:0]   w_zero;
  logic                w_cu;
  logic                w_cd;
  logic                w_load_bad;
  logic                w_tc;
  logic [3:0]          w_d;
  logic [3:0]          w_lv;

  // w_cu/w_cd ripple the "all lower digits at limit" condition upward
  always_comb begin
    w_cnt_nxt  = r_count;
    w_load_bcd = '0;
    w_load_bad = 1'b0;
    w_nine     = '0;
    w_zero     = '0;
    w_cu       = 1'b1;
    w_cd       = 1'b1;
    w_d        = '0;
    w_lv       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d       = r_count[4*i +: 4];
      w_nine[i] = (w_d == 4'd9);
      w_zero[i] = (w_d == 4'd0);
      if (up_dn && w_cu) begin
        w_cnt_nxt[4*i +: 4] = w_nine[i] ? 4'd0 : w_d + 4'd1;
      end else if (!up_dn && w_cd) begin
        w_cnt_nxt[4*i +: 4] = w_zero[i] ? 4'd9 : w_d - 4'd1;
      end
      w_cu = w_cu & w_nine[i];
      w_cd = w_cd & w_zero[i];
      w_lv = load_val[4*i +: 4];
      if (w_lv > 4'd9) begin
        w_load_bad = 1'b1;
      end else begin
        w_load_bcd[4*i +: 4] = w_lv;
      end
    end
  end

  assign w_tc = en & (up_dn ? (&w_nine) : (&w_zero));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= INIT;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (clr) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_count    <= w_load_bcd;
      r_wrap     <= 1'b0;
      r_load_err <= w_load_bad;
    end else if (en) begin
      if (!(SAT && w_tc)) begin
        r_count <= w_cnt_nxt;
      end
      r_wrap     <= !SAT && w_tc;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tc       = w_tc;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_sync_n.sv
// Scoreboard bench for bcd_counter_sync_n (DIGITS=3, INIT=0).
// Follows BCD_COUNTER_SATURATE_EN when compiled with it.
module tb_bcd_counter_sync_n;

  localparam int D = 3;
  localparam int W = 4*D;
`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         clr      = 1'b0;
  logic         en       = 1'b0;
  logic         up_dn    = 1'b1;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         load_err;

  bcd_counter_sync_n #(.DIGITS(D), .INIT('0)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_tc;
    int           due;
    logic [W-1:0] cnt;
    logic         wr;
    logic         er;
    logic         t;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(bit is_tc, int due, logic [W-1:0] c,
                      logic w, logic e, logic t, string nm);
    exp_t x;
    x.is_tc = is_tc;
    x.due   = due;
    x.cnt   = c;
    x.wr    = w;
    x.er    = e;
    x.t     = t;
    x.name  = nm;
    q.push_back(x);
  endtask

  // Apply one input vector; tc is checked this cycle, state after the edge.
  task automatic vec(string nm, bit c, bit l, logic [W-1:0] lv,
                     bit e, bit ud, bit t,
                     logic [W-1:0] rc, bit rw, bit re);
    @(posedge clk);
    #1;
    clr      = c;
    load     = l;
    load_val = lv;
    en       = e;
    up_dn    = ud;
    push(1'b1, cyc, '0, 1'b0, 1'b0, t, nm);
    push(1'b0, cyc + 1, rc, rw, re, 1'b0, nm);
  endtask

  task automatic chk_now(string nm, logic [W-1:0] rc, bit rw, bit re);
    push(1'b0, cyc, rc, rw, re, 1'b0, nm);
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (e.due < cyc) begin
          n_bad++;
          $display("FAIL %s stale: due %0d seen %0d", e.name, e.due, cyc);
        end else if (e.is_tc) begin
          if (tc !== e.t) begin
            n_bad++;
            $display("FAIL %s tc: got %b want %b", e.name, tc, e.t);
          end
        end else if ({count, wrap, load_err} !== {e.cnt, e.wr, e.er}) begin
          n_bad++;
          $display("FAIL %s: got cnt=%h wrap=%b err=%b want cnt=%h wrap=%b err=%b",
                   e.name, count, wrap, load_err, e.cnt, e.wr, e.er);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_now("reset_state", 12'h000, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // async reset mid-count
    vec("ld457",     0, 1, 12'h457, 0, 1, 0, 12'h457, 0, 0);
    vec("up458",     0, 0, 12'h000, 1, 1, 0, 12'h458, 0, 0);
    vec("hold458",   0, 0, 12'h000, 0, 1, 0, 12'h458, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    chk_now("async_rst", 12'h000, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // up wrap
    vec("ld998",     0, 1, 12'h998, 1, 1, 0, 12'h998, 0, 0);
    vec("up999",     0, 0, 12'h000, 1, 1, 0, 12'h999, 0, 0);
    vec("wrap_up",   0, 0, 12'h000, 1, 1, 1,
        SAT ? 12'h999 : 12'h000, !SAT, 0);
    vec("up001",     0, 0, 12'h000, 1, 1, SAT,
        SAT ? 12'h999 : 12'h001, 0, 0);

    // down borrow and wrap
    vec("ld100",     0, 1, 12'h100, 0, 0, 0, 12'h100, 0, 0);
    vec("dn099",     0, 0, 12'h000, 1, 0, 0, 12'h099, 0, 0);
    vec("dn098",     0, 0, 12'h000, 1, 0, 0, 12'h098, 0, 0);
    vec("ld000",     0, 1, 12'h000, 0, 0, 0, 12'h000, 0, 0);
    vec("wrap_dn",   0, 0, 12'h000, 1, 0, 1,
        SAT ? 12'h000 : 12'h999, !SAT, 0);
    vec("idle_dn",   0, 0, 12'h000, 0, 0, 0,
        SAT ? 12'h000 : 12'h999, 0, 0);

    // load validation and clear priority
    vec("ld3A5",     0, 1, 12'h3A5, 0, 1, 0, 12'h305, 0, 1);
    vec("err_drop",  0, 0, 12'h000, 0, 1, 0, 12'h305, 0, 0);
    vec("ldFFF",     0, 1, 12'hFFF, 1, 1, 0, 12'h000, 0, 1);
    vec("ld3AF",     0, 1, 12'h3AF, 0, 1, 0, 12'h300, 0, 1);
    vec("clr_ldbad", 1, 1, 12'h3AF, 0, 1, 0, 12'h000, 0, 0);
    vec("clr_prio",  1, 1, 12'h123, 1, 1, 0, 12'h000, 0, 0);
    vec("ld_no_inc", 0, 1, 12'h123, 1, 1, 0, 12'h123, 0, 0);

    // mid-digit carry, tc gating by en
    vec("ld099",     0, 1, 12'h099, 0, 1, 0, 12'h099, 0, 0);
    vec("carry100",  0, 0, 12'h000, 1, 1, 0, 12'h100, 0, 0);
    vec("ld999",     0, 1, 12'h999, 0, 1, 0, 12'h999, 0, 0);
    vec("tc_gated",  0, 0, 12'h000, 0, 1, 0, 12'h999, 0, 0);
    vec("dn998",     0, 0, 12'h000, 1, 0, 0, 12'h998, 0, 0);

    // up_dn toggling, then hold
    vec("ld500",     0, 1, 12'h500, 0, 1, 0, 12'h500, 0, 0);
    vec("tog_up1",   0, 0, 12'h000, 1, 1, 0, 12'h501, 0, 0);
    vec("tog_dn1",   0, 0, 12'h000, 1, 0, 0, 12'h500, 0, 0);
    vec("tog_up2",   0, 0, 12'h000, 1, 1, 0, 12'h501, 0, 0);
    vec("tog_dn2",   0, 0, 12'h000, 1, 0, 0, 12'h500, 0, 0);
    vec("hold_a",    0, 0, 12'h000, 0, 1, 0, 12'h500, 0, 0);
    vec("hold_b",    0, 0, 12'h000, 0, 0, 0, 12'h500, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_sync_n.md
Name: bcd_counter_sync_n

Overview:
Parametrised, fully synchronous multi-digit BCD counter. It succeeds the ripple-clocked 3-digit decimal counter: all digits share one clock, and carry/borrow is generated combinationally between digits. It adds up/down counting, count enable, synchronous clear, parallel load with BCD validation, terminal-count and wrap flags. It is used as a decimal event/time counter feeding display and timer logic.

Parameters:
DIGITS, 3, number of BCD digits; range 1..8; count width is 4*DIGITS.
INIT, 0 (all digits), reset value of count, 4*DIGITS bits; every nibble must be 0..9, enforced by an elaboration-time check that fails the build otherwise.

Ports:
clk  input  1  rising-edge clock, sole clock of the block
reset  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear to all-zero
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_val  input  4*DIGITS  BCD value to load; nibble i is digit i, nibble 0 is the LSD
count  output  4*DIGITS  registered BCD count
tc  output  1  combinational terminal count
wrap  output  1  registered one-cycle pulse on wrap-around
load_err  output  1  registered one-cycle pulse when load_val contained a non-BCD nibble

Behaviour:
- Reset (asynchronous, active-high): count=INIT, wrap=0, load_err=0. Outputs hold these values while reset is high. Operation resumes on the first clk edge after reset deasserts.
- Per-edge priority is clr > load > en. With none asserted, count holds. wrap and load_err return to 0 on any edge where their condition is absent.
- clr: count=0, wrap=0, load_err=0. It overrides load and en in the same cycle.
- load (clr=0):
  - Each nibble of load_val in 0..9 is copied to its digit.
  - Any nibble in 10..15 is stored as 0, and load_err=1 on the next cycle.
  - en is ignored in a load cycle, and wrap=0.
- Count (en=1, clr=0, load=0):
  - Up: digit 0 always increments. Digit i>0 increments only when digits 0..i-1 are all 9. A digit at 9 that increments becomes 0.
  - Down: digit 0 always decrements. Digit i>0 decrements only when digits 0..i-1 are all 0. A digit at 0 that decrements becomes 9.
  - Carry and borrow chains are combinational within one cycle. Latency from the en edge to the updated count is 1 cycle.
- tc = en & (up_dn ? all digits 9 : all digits 0). It is combinational, with no registered dependence beyond count.
- wrap: registered. It equals 1 in the cycle after an edge where tc=1 and the counter actually counted, i.e. count went 9..9->0..0 up or 0..0->9..9 down.
- up_dn may change on any cycle and takes effect on the next counting edge, with no pipeline hazard.
- Any count state reached through a non-BCD path is a design error. No nibble may ever hold 10..15.
- Combinational paths: tc is the only combinational output.

Optional Feature:
Macro BCD_COUNTER_SATURATE_EN.
- Defined: the counter saturates. Counting up at all-9 holds all-9, and counting down at all-0 holds all-0. wrap is tied to 0. tc still asserts at the limit.
- Undefined (default): wrap-around behaviour exactly as described under Behaviour.

Test Plan:
1. Assert reset mid-count at 0x457 (DIGITS=3), asynchronously between edges -> count=INIT (0x000) immediately, without waiting for clk; wrap=0, load_err=0.
2. Load 0x998, up_dn=1, en=1 for 3 cycles -> count 0x999, then 0x000, then 0x001. tc=1 only while count=0x999. wrap=1 exactly in the cycle count=0x000. With BCD_COUNTER_SATURATE_EN: 0x999, 0x999, 0x999, and wrap stays 0.
3. Load 0x100, up_dn=0, en=1 -> 0x099, then 0x098. Load 0x000, count down once -> 0x999 with wrap pulse (saturate build: holds 0x000).
4. Load load_val=0x3A5 -> count=0x305, load_err=1 for one cycle, then 0.
5. Same cycle clr=1, load=1 (0x123), en=1 -> count=0x000. Next cycle load=1, en=1 -> 0x123, with no increment that cycle.
6. Toggle up_dn every cycle from 0x500 with en=1 -> 0x501, 0x500, 0x501, ...; en=0 for 2 cycles -> count holds, tc=0.
